// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the 3x3 window payload type.
package cnn_pkg;

  localparam int unsigned KERNEL_SIZE        = 3;
  localparam int unsigned KERNEL_ELEMENT_NUM = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned PIXEL_WIDTH        = 32;

  // Row-major kernel-element order: [0]=top-left .. [8]=bottom-right.
  typedef logic [0:KERNEL_ELEMENT_NUM-1][PIXEL_WIDTH-1:0] window_t;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv_window_gen.
interface conv_window_gen_if
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_window [0:KERNEL_ELEMENT_NUM-1];
  logic                  o_last;

  // Window generator side.
  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_window, o_last
  );

  // Pixel source / window sink side.
  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_window, o_last
  );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// conv_line_buffer: DEPTH-deep shift FIFO; o_data is the word shifted in DEPTH shifts ago.
// Contents are intentionally not reset; the window generator masks stale rows.
module conv_line_buffer #(
  parameter int unsigned DEPTH      = 28,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

  // Shift one word in on every enabled cycle.
  always_ff @(posedge i_clk) begin
    if (i_shift) begin
      mem_q[0] <= i_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign o_data = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 sliding-window generator, raster-order input,
// valid convolution (no padding).
// Build option: CONV_WIN_STRIDE2_EN selects stride 2 (odd IMG_WIDTH/IMG_HEIGHT only);
// default build is stride 1.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic             i_clk,
  input logic             i_reset,
  input logic             i_enable,
  conv_window_gen_if.slave bus
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam int unsigned KN = KERNEL_ELEMENT_NUM;

  // Elaboration-time parameter sanity.
  if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_size
    $error("conv_window_gen: IMG_WIDTH and IMG_HEIGHT must be >= 3");
  end
`ifdef CONV_WIN_STRIDE2_EN
  if ((IMG_WIDTH % 2) == 0 || (IMG_HEIGHT % 2) == 0) begin : g_bad_stride2
    $error("conv_window_gen: stride 2 requires odd IMG_WIDTH and IMG_HEIGHT");
  end
`endif

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  accept_c, xfer_c, emit_c, pos_ok_c, row_end_c, frame_end_c;
  logic [DATA_WIDTH-1:0] lb1_out, lb2_out;
  logic [DATA_WIDTH-1:0] new_col [0:2];
  logic [DATA_WIDTH-1:0] hist_q  [0:5];
  logic [DATA_WIDTH-1:0] win_d   [0:KN-1];
  logic [DATA_WIDTH-1:0] win_out_q [0:KN-1];
  logic                  o_valid_q, o_last_q;

  assign bus.o_ready = i_enable && (!o_valid_q || bus.i_ready);
  assign accept_c    = bus.i_valid && bus.o_ready;
  assign xfer_c      = i_enable && o_valid_q && bus.i_ready;
  assign row_end_c   = (col_q == COL_LAST);
  assign frame_end_c = row_end_c && (row_q == ROW_LAST);

`ifdef CONV_WIN_STRIDE2_EN
  assign pos_ok_c = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2)) && !row_q[0] && !col_q[0];
`else
  assign pos_ok_c = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
`endif
  assign emit_c = accept_c && pos_ok_c;

  // Newest column of the window: two rows back, one row back, current pixel.
  assign new_col[0] = lb2_out;
  assign new_col[1] = lb1_out;
  assign new_col[2] = bus.i_data;

  conv_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lb_r1 (
    .i_clk   (i_clk),
    .i_shift (accept_c),
    .i_data  (bus.i_data),
    .o_data  (lb1_out)
  );

  conv_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_lb_r2 (
    .i_clk   (i_clk),
    .i_shift (accept_c),
    .i_data  (lb1_out),
    .o_data  (lb2_out)
  );

  // Raster position of the next pixel to be accepted.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept_c) begin
      if (row_end_c) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Position counters.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Window as it will look once the current pixel's column is shifted in.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[3*r]     = hist_q[2*r];
      win_d[3*r + 1] = hist_q[2*r + 1];
      win_d[3*r + 2] = new_col[r];
    end
  end

  // Two older window columns; newest column comes straight from the inputs.
  always_ff @(posedge i_clk) begin
    if (accept_c) begin
      for (int r = 0; r < 3; r++) begin
        hist_q[2*r]     <= hist_q[2*r + 1];
        hist_q[2*r + 1] <= new_col[r];
      end
    end
  end

  // Output window register with hold-while-stalled behaviour.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      for (int i = 0; i < int'(KN); i++) win_out_q[i] <= '0;
    end else if (emit_c) begin
      o_valid_q <= 1'b1;
      o_last_q  <= frame_end_c;
      for (int i = 0; i < int'(KN); i++) win_out_q[i] <= win_d[i];
    end else if (xfer_c) begin
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end
  end

  assign bus.o_valid  = o_valid_q;
  assign bus.o_last   = o_last_q;
  assign bus.o_window = win_out_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized self-checking bench for conv_window_gen against a frame-level window model.
module tb_conv_window_gen;

  localparam int unsigned DW = 32;
  localparam int W = 5;
`ifdef CONV_WIN_STRIDE2_EN
  localparam int H  = 5;
  localparam int NW = ((W - 1) / 2) * ((H - 1) / 2);
`else
  localparam int H  = 4;
  localparam int NW = (W - 2) * (H - 2);
`endif
  localparam int NPIX = W * H;
  localparam int unsigned FW = 9 * DW;
  localparam int unsigned CW = FW + 1;

  typedef logic [FW-1:0] flat_t;
  typedef logic [CW-1:0] cw_t;
  typedef struct packed { flat_t w; logic last; } ent_t;

  logic i_clk, i_reset, i_enable;
  conv_window_gen_if #(.DATA_WIDTH(DW)) bus ();

  conv_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .bus      (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_fail = 0;
  ent_t q[$];        // windows the model says are pending at the output
  ent_t xlog[$];     // windows observed transferring out of the DUT
  logic [DW-1:0] img [0:NPIX-1];
  int n_pix = 0;     // raster index of the next accepted pixel
  bit last_acc;

  task automatic chk(input string nm, input cw_t act, input cw_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic flat_t dut_flat();
    flat_t f;
    for (int i = 0; i < 9; i++) f[(8-i)*DW +: DW] = bus.o_window[i];
    return f;
  endfunction

  function automatic flat_t mk(input int v [9]);
    flat_t f;
    for (int i = 0; i < 9; i++) f[(8-i)*DW +: DW] = DW'(v[i]);
    return f;
  endfunction

  // Model: store the pixel in its frame position and queue any window it completes.
  task automatic model_accept(input logic [DW-1:0] d);
    int r, c;
    bit em;
    ent_t e;
    r = n_pix / W;
    c = n_pix % W;
    img[n_pix] = d;
`ifdef CONV_WIN_STRIDE2_EN
    em = (r >= 2) && (c >= 2) && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
`else
    em = (r >= 2) && (c >= 2);
`endif
    if (em) begin
      for (int i = 0; i < 9; i++)
        e.w[(8-i)*DW +: DW] = img[(r - 2 + i / 3) * W + (c - 2 + i % 3)];
      e.last = (n_pix == NPIX - 1);
      q.push_back(e);
    end
    n_pix = (n_pix + 1) % NPIX;
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic en, input logic rdy);
    bit exp_rdy, xfer;
    bus.i_valid = v;
    bus.i_data  = d;
    i_enable    = en;
    bus.i_ready = rdy;
    #1;
    exp_rdy = en && (q.size() == 0 || rdy);
    chk("o_ready", cw_t'(bus.o_ready), cw_t'(exp_rdy));
    chk("o_valid", cw_t'(bus.o_valid), cw_t'(q.size() != 0));
    if (q.size() != 0) begin
      chk("o_window", cw_t'(dut_flat()), cw_t'(q[0].w));
      chk("o_last", cw_t'(bus.o_last), cw_t'(q[0].last));
    end
    xfer = en && (q.size() != 0) && rdy;
    last_acc = v && exp_rdy;
    if (xfer) begin
      xlog.push_back('{w: dut_flat(), last: bus.o_last});
      void'(q.pop_front());
    end
    if (last_acc) model_accept(d);
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    i_reset     = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    i_enable    = 1'b0;
    #1;
    chk("rst_o_valid", cw_t'(bus.o_valid), cw_t'(0));
    chk("rst_o_last", cw_t'(bus.o_last), cw_t'(0));
    chk("rst_o_window", cw_t'(dut_flat()), cw_t'(0));
    q.delete();
    n_pix = 0;
    repeat (cycles) @(posedge i_clk);
    #1;
    chk("rst_hold_o_valid", cw_t'(bus.o_valid), cw_t'(0));
    i_reset = 1'b1;
    #1;
  endtask

  // Feed npix pixels (value = raster index mod frame size) then drain the output.
  task automatic stream(input int npix, input int pv, input int pe, input int pr, input bit hold);
    int k = 0;
    int cyc = 0;
    bit held = 0;
    while (k < npix && cyc < 3000) begin
      if (hold && !held && q.size() != 0) begin
        held = 1;
        repeat (10) step(1'b1, DW'(k % NPIX), 1'b1, 1'b0);
      end else begin
        step(($urandom_range(99) < 32'(pv)), DW'(k % NPIX),
             ($urandom_range(99) < 32'(pe)), ($urandom_range(99) < 32'(pr)));
        if (last_acc) k++;
      end
      cyc++;
    end
    chk("stream_timeout", cw_t'(k), cw_t'(npix));
    cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      step(1'b0, '0, 1'b1, 1'b1);
      cyc++;
    end
    chk("drain_timeout", cw_t'(q.size()), cw_t'(0));
    repeat (2) step(1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    int b1, b2, b3, b4, b5;
    int a_first [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
`ifdef CONV_WIN_STRIDE2_EN
    int a_last [9]  = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    int a_sec [9]   = '{2, 3, 4, 7, 8, 9, 12, 13, 14};
`else
    int a_last [9]  = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
`endif

    do_reset(3);

    // Full-rate single frame.
    b1 = xlog.size();
    stream(NPIX, 100, 100, 100, 0);
    chk("t1_count", cw_t'(xlog.size() - b1), cw_t'(NW));
    if (xlog.size() - b1 == NW) begin
      chk("t1_first", cw_t'(xlog[b1].w), cw_t'(mk(a_first)));
      chk("t1_first_last", cw_t'(xlog[b1].last), cw_t'(0));
      chk("t1_final", cw_t'(xlog[b1+NW-1].w), cw_t'(mk(a_last)));
      chk("t1_final_last", cw_t'(xlog[b1+NW-1].last), cw_t'(1));
      for (int i = 0; i < NW - 1; i++)
        chk("t1_mid_last", cw_t'(xlog[b1+i].last), cw_t'(0));
`ifdef CONV_WIN_STRIDE2_EN
      chk("t1_second", cw_t'(xlog[b1+1].w), cw_t'(mk(a_sec)));
`endif
    end

    // Downstream stall right after the first window.
    b2 = xlog.size();
    stream(NPIX, 100, 100, 100, 1);
    chk("t2_count", cw_t'(xlog.size() - b2), cw_t'(NW));
    if (xlog.size() - b2 == NW) begin
      for (int i = 0; i < NW; i++)
        chk("t2_seq", cw_t'(xlog[b2+i]), cw_t'(xlog[b1+i]));
    end

    // Random valid gaps, enable toggling and backpressure.
    b3 = xlog.size();
    stream(NPIX, 60, 70, 65, 0);
    chk("t3_count", cw_t'(xlog.size() - b3), cw_t'(NW));
    if (xlog.size() - b3 == NW) begin
      for (int i = 0; i < NW; i++)
        chk("t3_seq", cw_t'(xlog[b3+i]), cw_t'(xlog[b1+i]));
    end

    // Reset mid-frame, then a fresh frame.
    stream(10, 100, 100, 100, 0);
    do_reset(2);
    b4 = xlog.size();
    stream(NPIX, 80, 90, 80, 0);
    chk("t4_count", cw_t'(xlog.size() - b4), cw_t'(NW));
    if (xlog.size() - b4 == NW)
      chk("t4_first", cw_t'(xlog[b4].w), cw_t'(mk(a_first)));

    // Two frames back-to-back.
    b5 = xlog.size();
    stream(2 * NPIX, 85, 90, 85, 0);
    chk("t5_count", cw_t'(xlog.size() - b5), cw_t'(2 * NW));
    if (xlog.size() - b5 == 2 * NW) begin
      chk("t5_frame2_first", cw_t'(xlog[b5+NW].w), cw_t'(xlog[b5].w));
      chk("t5_frame2_last", cw_t'(xlog[b5+2*NW-1].last), cw_t'(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
